// File: rtl/lane_arb_pkg.sv
// Shared types and the round-robin pick function for lane_arb_ctrl.
package lane_arb_pkg;

  typedef logic [3:0][1:0] lane_t;
  typedef logic [7:0]      byte_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} arb_state_e;

  localparam int MAX_REQ = 8;

  // One-hot pick of the first set bit of valid at or after ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] onehot_rr(input logic [MAX_REQ-1:0] valid,
                                                   input logic [2:0]         ptr,
                                                   input int                 n);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int                 idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n && !found) begin
        idx = (int'(ptr) + k) % n;
        if (valid[idx[2:0]]) begin
          gnt[idx[2:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/lane_arb_ctrl_if.sv
// Requester-side bus of lane_arb_ctrl; req_lock exists only with LANE_ARB_CTRL_LOCK_EN.
interface lane_arb_ctrl_if #(parameter int N_REQ = 4);
  import lane_arb_pkg::*;

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0][7:0] req_data;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ-1:0]      rsp_valid;
  lane_t                 rsp_data;
`ifdef LANE_ARB_CTRL_LOCK_EN
  logic [N_REQ-1:0]      req_lock;

  modport master (output req_valid, req_data, req_lock, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_data, req_lock, output req_ready, rsp_valid, rsp_data);
`else
  modport master (output req_valid, req_data, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_data, output req_ready, rsp_valid, rsp_data);
`endif

endinterface

// File: rtl/lane_arb_tag_pipe.sv
// UNIT_LAT-deep {valid, id} delay line that tracks which requester owns each unit result.
module lane_arb_tag_pipe #(
  parameter int UNIT_LAT = 2,
  parameter int ID_W     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  input  logic [ID_W-1:0] in_id,
  output logic            out_vld,
  output logic [ID_W-1:0] out_id,
  output logic            any_vld
);

  logic [UNIT_LAT-1:0]           vld_p;
  logic [UNIT_LAT-1:0][ID_W-1:0] id_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_vld;
      for (int k = 1; k < UNIT_LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // Ids are qualified by vld_p, so they carry no reset.
  always_ff @(posedge clk) begin
    id_p[0] <= in_id;
    for (int k = 1; k < UNIT_LAT; k++) id_p[k] <= id_p[k-1];
  end

  assign out_vld = vld_p[UNIT_LAT-1];
  assign out_id  = id_p[UNIT_LAT-1];
  assign any_vld = |vld_p;

endmodule

// File: rtl/lane_arb_ctrl.sv
// Round-robin arbiter/sequencer sharing one byte-to-lane unit among N_REQ requesters.
// Optional macro LANE_ARB_CTRL_LOCK_EN: req_lock keeps a granted requester at the head.
module lane_arb_ctrl
  import lane_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int UNIT_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           arb_en,
  lane_arb_ctrl_if.slave bus,
  output logic           unit_x0,
  output byte_t          unit_x1,
  input  lane_t          unit_x2,
  output logic           busy
);

  localparam int ID_W = $clog2(N_REQ);

  arb_state_e         state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_nxt;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    issue_id_p0;
  logic [ID_W-1:0]    tag_id;
  logic [MAX_REQ-1:0] rr;
  logic [N_REQ-1:0]   gnt;
  logic               granted;
  logic               tag_vld;
  logic               tag_any;

  // Grant depends only on req_valid, ptr and the registered state.
  always_comb begin
    rr      = onehot_rr(MAX_REQ'(bus.req_valid), 3'(ptr), N_REQ);
    gnt     = (state == RUN) ? rr[N_REQ-1:0] : '0;
    granted = |gnt;
    win_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) win_id = ID_W'(i);
    end
    ptr_nxt = (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + ID_W'(1);
`ifdef LANE_ARB_CTRL_LOCK_EN
    if (bus.req_lock[win_id]) ptr_nxt = win_id;
`endif
  end

  assign bus.req_ready = gnt;
  assign busy          = unit_x0 | tag_any;

  lane_arb_tag_pipe #(
    .UNIT_LAT (UNIT_LAT),
    .ID_W     (ID_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (unit_x0),
    .in_id   (issue_id_p0),
    .out_vld (tag_vld),
    .out_id  (tag_id),
    .any_vld (tag_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      unit_x0       <= 1'b0;
      unit_x1       <= '0;
      issue_id_p0   <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
    end else begin
      case (state)
        IDLE:    if (arb_en) state <= RUN;
        RUN:     if (!arb_en) state <= DRAIN;
        DRAIN:   if (arb_en) state <= RUN;
                 else if (!busy) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (granted) ptr <= ptr_nxt;
      // Issue stage: operand and owner id launched together
      unit_x0     <= granted;
      unit_x1     <= granted ? bus.req_data[win_id] : '0;
      issue_id_p0 <= win_id;
      // Response stage: tag leaves the delay line alongside unit_x2
      bus.rsp_valid <= tag_vld ? (N_REQ'(1) << tag_id) : '0;
      if (tag_vld) bus.rsp_data <= unit_x2;
    end
  end

endmodule

// File: tb/tb_lane_arb_ctrl.sv
// Directed bench for lane_arb_ctrl (N_REQ=4, UNIT_LAT=2) with a two-stage unit model.
module tb_lane_arb_ctrl;
  import lane_arb_pkg::*;

  localparam int N_REQ    = 4;
  localparam int UNIT_LAT = 2;

  logic  clk    = 1'b0;
  logic  rst_n  = 1'b1;
  logic  arb_en = 1'b0;
  logic  unit_x0;
  byte_t unit_x1;
  lane_t unit_x2;
  logic  busy;
  byte_t u_p0, u_p1;
  int    passed = 0;
  int    total  = 0;

  lane_arb_ctrl_if #(.N_REQ(N_REQ)) bus ();

  lane_arb_ctrl #(.N_REQ(N_REQ), .UNIT_LAT(UNIT_LAT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_en  (arb_en),
    .bus     (bus),
    .unit_x0 (unit_x0),
    .unit_x1 (unit_x1),
    .unit_x2 (unit_x2),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Shared unit: result is the operand byte viewed as four 2-bit lanes, UNIT_LAT cycles later.
  always @(posedge clk) begin
    u_p0 <= unit_x1;
    u_p1 <= u_p0;
  end
  assign unit_x2 = lane_t'(u_p1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic byte_t dat(input int r);
    return byte_t'(17 * (r + 1));
  endfunction

  initial begin
    bus.req_valid = '0;
    bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
`ifdef LANE_ARB_CTRL_LOCK_EN
    bus.req_lock  = '0;
`endif
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_x0", unit_x0, 0);
    chk("rst_x1", unit_x1, 0);
    chk("rst_rspv", bus.rsp_valid, 0);
    chk("rst_rspd", bus.rsp_data, 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Fairness: all four valid; IDLE grants nothing until RUN is registered
    arb_en        = 1'b1;
    bus.req_valid = 4'hF;
    #1 chk("idle_ready", bus.req_ready, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      #1;
      chk($sformatf("rr_ready_%0d", k), bus.req_ready, 32'(1) << (k % 4));
      chk($sformatf("rr_x0_%0d", k), unit_x0, (k > 0) ? 1 : 0);
      if (k > 0) chk($sformatf("rr_x1_%0d", k), unit_x1, dat((k - 1) % 4));
      if (k >= 4) begin
        chk($sformatf("rr_rspv_%0d", k), bus.rsp_valid, 32'(1) << ((k - 4) % 4));
        chk($sformatf("rr_rspd_%0d", k), bus.rsp_data, dat((k - 4) % 4));
      end else begin
        chk($sformatf("rr_rspv_%0d", k), bus.rsp_valid, 0);
      end
    end

    // Drain: the grant already offered completes, then no further grants
    arb_en = 1'b0;
    for (int d = 0; d < 5; d++) begin
      tick();
      #1;
      chk($sformatf("dr_ready_%0d", d), bus.req_ready, 0);
      chk($sformatf("dr_x0_%0d", d), unit_x0, (d == 0) ? 1 : 0);
      chk($sformatf("dr_busy_%0d", d), busy, (d < 3) ? 1 : 0);
      if (d < 4) begin
        chk($sformatf("dr_rspv_%0d", d), bus.rsp_valid, 32'(1) << d);
        chk($sformatf("dr_rspd_%0d", d), bus.rsp_data, dat(d));
      end else begin
        chk($sformatf("dr_rspv_%0d", d), bus.rsp_valid, 0);
      end
    end

    // Reset with three tags in flight
    arb_en = 1'b1;
    tick();
    #1 chk("mr_ready_run", bus.req_ready, 4'b0001);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_ready", bus.req_ready, 0);
    chk("mr_x0", unit_x0, 0);
    chk("mr_x1", unit_x1, 0);
    chk("mr_rspv", bus.rsp_valid, 0);
    chk("mr_rspd", bus.rsp_data, 0);
    chk("mr_busy", busy, 0);
    tick();
    tick();
    arb_en        = 1'b0;
    bus.req_valid = '0;
    rst_n         = 1'b1;
    for (int w = 0; w < 6; w++) begin
      tick();
      #1;
      chk($sformatf("mr_post_rspv_%0d", w), bus.rsp_valid, 0);
      chk($sformatf("mr_post_busy_%0d", w), busy, 0);
    end

    // Sparse: only req 3, pointer wraps to 0; then req 0; then latency of req 2
    arb_en        = 1'b1;
    bus.req_valid = 4'b1000;
    #1 chk("sp_idle_ready", bus.req_ready, 0);
    tick();
    #1 chk("sp_ready3", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = 4'b0001;
    #1;
    chk("sp_ready0", bus.req_ready, 4'b0001);
    chk("sp_x1_3", unit_x1, 8'h44);
    tick();
    bus.req_valid   = 4'b0100;
    bus.req_data[2] = 8'hA5;
    #1;
    chk("lat_ready2", bus.req_ready, 4'b0100);
    chk("sp_x1_0", unit_x1, 8'h11);
    tick();
    bus.req_valid = '0;
    #1;
    chk("lat_x1", unit_x1, 8'hA5);
    chk("lat_ready_none", bus.req_ready, 0);
    chk("lat_rspv_early", bus.rsp_valid, 0);
    tick();
    #1;
    chk("sp_rspv3", bus.rsp_valid, 4'b1000);
    chk("sp_rspd3", bus.rsp_data, 8'h44);
    chk("sp_x1_idle", unit_x1, 0);
    tick();
    #1;
    chk("sp_rspv0", bus.rsp_valid, 4'b0001);
    chk("sp_rspd0", bus.rsp_data, 8'h11);
    tick();
    #1;
    chk("lat_rspv", bus.rsp_valid, 4'b0100);
    chk("lat_rspd", bus.rsp_data, 8'hA5);
    tick();
    #1 chk("lat_rspv_after", bus.rsp_valid, 0);

`ifdef LANE_ARB_CTRL_LOCK_EN
    // Lock: pointer sits at 3; req 1 alone first, then held at the head while locked
    bus.req_valid = 4'b0010;
    bus.req_lock  = 4'b0010;
    #1 chk("lk_first", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = 4'hF;
    for (int l = 0; l < 4; l++) begin
      #1 chk($sformatf("lk_hold_%0d", l), bus.req_ready, 4'b0010);
      tick();
    end
    bus.req_lock = '0;
    #1 chk("lk_release", bus.req_ready, 4'b0010);
    tick();
    #1 chk("lk_next", bus.req_ready, 4'b0100);
    bus.req_valid = '0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
